// File: rtl/sd_cmd_engine.sv
// SD host CMD-line sequencer: sends a 48-bit command frame with CRC7,
// optionally receives and checks a 48-bit response, then idles the line.
module sd_crc7 (
    input  logic       clk,
    input  logic       rst,
    input  logic       crc_rst,
    input  logic       crc_en,
    input  logic       crc_dat,
    output logic [6:0] crc
);
    logic [6:0] base;
    logic       fb;

    // crc_rst restarts from zero and absorbs crc_dat in the same step
    always_comb begin
        base = crc_rst ? 7'd0 : crc;
        fb   = crc_dat ^ base[6];
    end

    always_ff @(posedge clk) begin
        if (rst) crc <= 7'd0;
        else if (crc_rst || crc_en)
            crc <= {base[5:3], base[2] ^ fb, base[1:0], fb};
    end
endmodule

module sd_cmd_engine #(
    parameter int NCR_MAX = 64,
    parameter int NCC_GAP = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bit_tick,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic        resp_en,
    input  logic        resp_crc_chk,
    output logic        sd_cmd_o,
    output logic        sd_cmd_oe,
    input  logic        sd_cmd_i,
    output logic        done,
    output logic [31:0] resp_data,
    output logic [5:0]  resp_index,
    output logic        err_timeout,
    output logic        err_crc,
    output logic        err_end
);
    typedef enum logic [2:0] {
        IDLE, TX_HDR, TX_CRC, TX_END, NCR, RX, GAP
    } state_t;

    state_t      state, state_nxt;
    logic [6:0]  cnt;
    logic [39:0] hdr;
    logic        ren_q, chk_q;
    logic [37:0] rx_sr;
    logic [6:0]  rx_crc;
    logic        crc_rst, crc_en, crc_dat;
    logic [6:0]  crc;
    logic        o_nxt, oe_nxt, done_nxt;
    logic        ncr_last, gap_last;

    assign cmd_ready = (state == IDLE);
    assign ncr_last  = (cnt == 7'(NCR_MAX - 1));
    assign gap_last  = (cnt == 7'(NCC_GAP - 1));

    sd_crc7 u_crc (
        .clk     (clk),
        .rst     (rst),
        .crc_rst (crc_rst),
        .crc_en  (crc_en),
        .crc_dat (crc_dat),
        .crc     (crc)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:   if (cmd_valid) state_nxt = TX_HDR;
            TX_HDR: if (bit_tick && cnt == 7'd39) state_nxt = TX_CRC;
            TX_CRC: if (bit_tick && cnt == 7'd6) state_nxt = TX_END;
            TX_END: if (bit_tick) state_nxt = ren_q ? NCR : GAP;
            NCR: begin
                if (bit_tick) begin
                    if (!sd_cmd_i)     state_nxt = RX;
                    else if (ncr_last) state_nxt = GAP;
                end
            end
            RX:     if (bit_tick && cnt == 7'd46) state_nxt = GAP;
            GAP:    if (bit_tick && gap_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_nxt    = sd_cmd_o;
        oe_nxt   = sd_cmd_oe;
        done_nxt = 1'b0;
        if (bit_tick) begin
            unique case (state)
                TX_HDR: begin o_nxt = hdr[39]; oe_nxt = 1'b1; end
                TX_CRC: begin
                    o_nxt  = crc[3'd6 - cnt[2:0]];
                    oe_nxt = 1'b1;
                end
                TX_END: begin o_nxt = 1'b1; oe_nxt = 1'b1; end
                NCR, RX: begin o_nxt = 1'b1; oe_nxt = 1'b0; end
                GAP: begin
                    o_nxt    = 1'b1;
                    oe_nxt   = 1'b0;
                    done_nxt = gap_last;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sd_cmd_o  <= 1'b1;
            sd_cmd_oe <= 1'b0;
            done      <= 1'b0;
        end else begin
            sd_cmd_o  <= o_nxt;
            sd_cmd_oe <= oe_nxt;
            done      <= done_nxt;
        end
    end

    // The single CRC engine serves TX generation first, then RX checking
    always_comb begin
        crc_rst = 1'b0;
        crc_en  = 1'b0;
        crc_dat = 1'b0;
        if (bit_tick) begin
            unique case (state)
                TX_HDR: begin
                    crc_rst = (cnt == 7'd0);
                    crc_en  = (cnt != 7'd0);
                    crc_dat = hdr[39];
                end
                NCR: crc_rst = !sd_cmd_i;
                RX: begin
                    crc_en  = (cnt < 7'd39);
                    crc_dat = sd_cmd_i;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= 7'd0;
            hdr         <= 40'd0;
            ren_q       <= 1'b0;
            chk_q       <= 1'b0;
            rx_sr       <= 38'd0;
            rx_crc      <= 7'd0;
            resp_data   <= 32'd0;
            resp_index  <= 6'd0;
            err_timeout <= 1'b0;
            err_crc     <= 1'b0;
            err_end     <= 1'b0;
        end else if (state == IDLE) begin
            cnt <= 7'd0;
            if (cmd_valid) begin
                hdr         <= {2'b01, cmd_index, cmd_arg};
                ren_q       <= resp_en;
                chk_q       <= resp_crc_chk;
                err_timeout <= 1'b0;
                err_crc     <= 1'b0;
                err_end     <= 1'b0;
            end
        end else if (bit_tick) begin
            cnt <= (state_nxt != state) ? 7'd0 : cnt + 7'd1;
            if (state == TX_HDR) hdr <= {hdr[38:0], 1'b0};
            if (state == NCR && sd_cmd_i && ncr_last) err_timeout <= 1'b1;
            // Transmission bit shifts out of rx_sr's top; it is never checked
            if (state == RX) begin
                if (cnt < 7'd39) begin
                    rx_sr <= {rx_sr[36:0], sd_cmd_i};
                end else if (cnt < 7'd46) begin
                    rx_crc <= {rx_crc[5:0], sd_cmd_i};
                end else begin
                    resp_index <= rx_sr[37:32];
                    resp_data  <= rx_sr[31:0];
                    err_crc    <= chk_q && (rx_crc != crc);
                    err_end    <= !sd_cmd_i;
                end
            end
        end
    end
endmodule

// File: tb/tb_sd_cmd_engine.sv
// Bench for sd_cmd_engine: directed SD command cases plus randomized
// transactions checked against a frame/CRC7 reference model.
module tb_sd_cmd_engine;
    logic        clk = 0;
    logic        rst = 1;
    logic        bit_tick = 0;
    logic        cmd_valid = 0;
    logic        cmd_ready;
    logic [5:0]  cmd_index = 0;
    logic [31:0] cmd_arg = 0;
    logic        resp_en = 0;
    logic        resp_crc_chk = 0;
    logic        sd_cmd_o;
    logic        sd_cmd_oe;
    logic        sd_cmd_i = 1;
    logic        done;
    logic [31:0] resp_data;
    logic [5:0]  resp_index;
    logic        err_timeout;
    logic        err_crc;
    logic        err_end;

    sd_cmd_engine #(.NCR_MAX(64), .NCC_GAP(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .bit_tick     (bit_tick),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_index    (cmd_index),
        .cmd_arg      (cmd_arg),
        .resp_en      (resp_en),
        .resp_crc_chk (resp_crc_chk),
        .sd_cmd_o     (sd_cmd_o),
        .sd_cmd_oe    (sd_cmd_oe),
        .sd_cmd_i     (sd_cmd_i),
        .done         (done),
        .resp_data    (resp_data),
        .resp_index   (resp_index),
        .err_timeout  (err_timeout),
        .err_crc      (err_crc),
        .err_end      (err_end)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          tdiv = 4;
    bit          stall = 0;
    logic [2:0]  cap_q[$];
    logic        rsp_q[$];
    logic [5:0]  m_ridx = 0;
    logic [31:0] m_rdata = 0;

    // Tick generator, line recorder and card-side responder
    initial begin
        int dc;
        dc = 0;
        forever begin
            @(negedge clk);
            if (bit_tick) cap_q.push_back({err_timeout, sd_cmd_oe, sd_cmd_o});
            bit_tick = 0;
            if (!stall) begin
                dc++;
                if (dc >= tdiv) begin
                    dc = 0;
                    if (!(cmd_valid && cmd_ready)) bit_tick = 1;
                end
            end
            if (bit_tick) sd_cmd_i = (rsp_q.size() > 0) ? rsp_q.pop_front() : 1'b1;
        end
    end

    function automatic logic [6:0] crc7_of(input logic [39:0] m);
        logic [6:0] c;
        logic fb;
        c = 0;
        for (int i = 39; i >= 0; i--) begin
            fb = m[i] ^ c[6];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    function automatic logic [47:0] frame_of(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] m;
        m = {2'b01, idx, arg};
        return {m, crc7_of(m), 1'b1};
    endfunction

    function automatic logic [47:0] resp_of(input logic [5:0] idx, input logic [31:0] d,
                                            input bit bad_crc, input bit bad_end);
        logic [39:0] m;
        m = {2'b00, idx, d};
        return {m, crc7_of(m) ^ {6'd0, bad_crc}, !bad_end};
    endfunction

    task automatic issue(input logic [5:0] idx, input logic [31:0] arg, input logic ren,
                         input logic chk, input int d, input logic [47:0] rsp, input bit send);
        @(posedge clk); #1;
        cmd_index = idx; cmd_arg = arg; resp_en = ren; resp_crc_chk = chk; cmd_valid = 1;
        @(posedge clk); #1;
        cmd_valid = 0;
        cmd_index = 6'($urandom); cmd_arg = $urandom;
        resp_en = 1'($urandom); resp_crc_chk = 1'($urandom);
        cap_q.delete();
        rsp_q.delete();
        if (send) begin
            repeat (48 + d) rsp_q.push_back(1'b1);
            for (int i = 47; i >= 0; i--) rsp_q.push_back(rsp[i]);
        end
    endtask

    task automatic wait_done(output bit got, output logic rdy, output logic nxt);
        got = 0; rdy = 0;
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            if (done) begin got = 1; rdy = cmd_ready; break; end
        end
        @(posedge clk); #1;
        nxt = done;
    endtask

    task automatic scan(output logic [47:0] f, output int ntx, output int nall, output bit rest_ok);
        f = 0; ntx = 0; rest_ok = 1; nall = cap_q.size();
        foreach (cap_q[i]) begin
            if (cap_q[i][1]) ntx++;
            if (i < 48) f[47 - i] = cap_q[i][0];
            else if (cap_q[i][1:0] != 2'b01) rest_ok = 0;
        end
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if ({cmd_ready, sd_cmd_oe, sd_cmd_o, done} !== 4'b1010) begin
            n_bad++;
            $display("FAIL reset_ctl: got %b want 1010", {cmd_ready, sd_cmd_oe, sd_cmd_o, done});
        end
        rst = 0;
        @(posedge clk); #1;
        n_cmp++;
        if ({resp_data, resp_index, err_timeout, err_crc, err_end} !== 41'd0) begin
            n_bad++;
            $display("FAIL reset_stat: got %h want 0",
                     {resp_data, resp_index, err_timeout, err_crc, err_end});
        end
    endtask

    task automatic test_cmd0();
        bit got, ok; logic rdy, nxt; logic [47:0] f; int ntx, nall;
        tdiv = 4;
        issue(6'd0, 32'd0, 0, 0, 0, 48'd0, 0);
        wait_done(got, rdy, nxt);
        scan(f, ntx, nall, ok);
        n_cmp++;
        if (f !== 48'h400000000095) begin
            n_bad++; $display("FAIL cmd0_frame: got %h want 400000000095", f);
        end
        n_cmp++;
        if ({got, ntx, nall, ok} !== {1'b1, 32'd48, 32'd56, 1'b1}) begin
            n_bad++;
            $display("FAIL cmd0_timing: done %0d oe_ticks %0d ticks %0d idle_ok %0d want 1 48 56 1",
                     got, ntx, nall, ok);
        end
        n_cmp++;
        if ({rdy, nxt} !== 2'b10) begin
            n_bad++; $display("FAIL cmd0_done: ready/next %b want 10", {rdy, nxt});
        end
    endtask

    task automatic test_cmd8();
        bit got, ok; logic rdy, nxt; logic [47:0] f; int ntx, nall;
        tdiv = 3;
        issue(6'd8, 32'h1AA, 1, 1, 5, resp_of(6'd8, 32'h1AA, 0, 0), 1);
        wait_done(got, rdy, nxt);
        scan(f, ntx, nall, ok);
        m_ridx = 6'd8; m_rdata = 32'h1AA;
        n_cmp++;
        if (f !== 48'h48000001AA87) begin
            n_bad++; $display("FAIL cmd8_frame: got %h want 48000001aa87", f);
        end
        n_cmp++;
        if ({got, ntx, nall, ok} !== {1'b1, 32'd48, 32'd109, 1'b1}) begin
            n_bad++;
            $display("FAIL cmd8_timing: done %0d oe_ticks %0d ticks %0d idle_ok %0d want 1 48 109 1",
                     got, ntx, nall, ok);
        end
        n_cmp++;
        if ({resp_index, resp_data, err_timeout, err_crc, err_end} !== {6'd8, 32'h1AA, 3'b000}) begin
            n_bad++;
            $display("FAIL cmd8_resp: idx %h data %h err %b want 08 000001aa 000",
                     resp_index, resp_data, {err_timeout, err_crc, err_end});
        end
    endtask

    task automatic test_cmd17_crc();
        bit got, ok; logic rdy, nxt; logic [47:0] f, r; int ntx, nall;
        logic [31:0] d;
        d = $urandom;
        r = resp_of(6'd17, d, 1, 0);
        tdiv = 2;
        issue(6'd17, 32'd0, 1, 1, 2, r, 1);
        wait_done(got, rdy, nxt);
        scan(f, ntx, nall, ok);
        m_ridx = 6'd17; m_rdata = d;
        n_cmp++;
        if (f !== 48'h510000000055) begin
            n_bad++; $display("FAIL cmd17_frame: got %h want 510000000055", f);
        end
        n_cmp++;
        if ({got, err_timeout, err_crc, err_end, resp_data} !== {4'b1010, d}) begin
            n_bad++;
            $display("FAIL cmd17_badcrc: done/err %b data %h want 1010 %h",
                     {got, err_timeout, err_crc, err_end}, resp_data, d);
        end
        issue(6'd17, 32'd0, 1, 0, 2, r, 1);
        wait_done(got, rdy, nxt);
        n_cmp++;
        if ({got, err_timeout, err_crc, err_end} !== 4'b1000) begin
            n_bad++;
            $display("FAIL cmd17_nochk: done/err %b want 1000", {got, err_timeout, err_crc, err_end});
        end
        issue(6'd17, 32'd0, 1, 1, 0, resp_of(6'd17, d, 0, 1), 1);
        wait_done(got, rdy, nxt);
        n_cmp++;
        if ({got, err_timeout, err_crc, err_end} !== 4'b1001) begin
            n_bad++;
            $display("FAIL cmd17_endbit: done/err %b want 1001", {got, err_timeout, err_crc, err_end});
        end
    endtask

    task automatic test_timeout();
        bit got, ok; logic rdy, nxt; logic [47:0] f; int ntx, nall, first;
        tdiv = 2;
        issue(6'($urandom), $urandom, 1, 1, 0, 48'd0, 0);
        wait_done(got, rdy, nxt);
        scan(f, ntx, nall, ok);
        first = -1;
        foreach (cap_q[i]) if (first < 0 && cap_q[i][2]) first = i;
        n_cmp++;
        if ({got, nall, first} !== {1'b1, 32'd120, 32'd111}) begin
            n_bad++;
            $display("FAIL timeout_ticks: done %0d ticks %0d flag_at %0d want 1 120 111",
                     got, nall, first);
        end
        n_cmp++;
        if ({err_timeout, err_crc, err_end, resp_data, resp_index} !== {3'b100, m_rdata, m_ridx}) begin
            n_bad++;
            $display("FAIL timeout_stat: err %b data %h idx %h want 100 %h %h",
                     {err_timeout, err_crc, err_end}, resp_data, resp_index, m_rdata, m_ridx);
        end
    endtask

    task automatic test_rst_mid();
        bit got, ok; logic rdy, nxt; logic [47:0] f; int ntx, nall;
        tdiv = 4;
        issue(6'd17, $urandom, 1, 1, 0, 48'd0, 0);
        for (int i = 0; i < 2000 && cap_q.size() < 10; i++) @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk); #1;
        n_cmp++;
        if ({sd_cmd_oe, sd_cmd_o, cmd_ready, cap_q.size() >= 10} !== 4'b0111) begin
            n_bad++;
            $display("FAIL rst_mid: oe/o/ready/reached %b want 0111",
                     {sd_cmd_oe, sd_cmd_o, cmd_ready, cap_q.size() >= 10});
        end
        rst = 0;
        m_ridx = 0; m_rdata = 0;
        issue(6'd0, 32'd0, 0, 0, 0, 48'd0, 0);
        wait_done(got, rdy, nxt);
        scan(f, ntx, nall, ok);
        n_cmp++;
        if ({got, f} !== {1'b1, 48'h400000000095}) begin
            n_bad++; $display("FAIL rst_cmd0: done %0d frame %h want 1 400000000095", got, f);
        end
    endtask

    task automatic test_stall();
        bit got, ok; logic rdy, nxt; logic [47:0] f; int ntx, nall;
        logic [5:0] idx; logic [31:0] arg; logic [1:0] snap;
        idx = 6'($urandom); arg = $urandom;
        tdiv = 3;
        issue(idx, arg, 0, 0, 0, 48'd0, 0);
        for (int i = 0; i < 2000 && cap_q.size() < 20; i++) @(posedge clk);
        #1;
        stall = 1;
        @(posedge clk); #1;
        snap = {sd_cmd_oe, sd_cmd_o};
        repeat (40) @(posedge clk);
        #1;
        cmd_index = ~idx; cmd_arg = ~arg; resp_en = 1; cmd_valid = 1;
        repeat (2) @(posedge clk);
        #1;
        cmd_valid = 0;
        repeat (58) @(posedge clk);
        #1;
        n_cmp++;
        if ({sd_cmd_oe, sd_cmd_o} !== snap) begin
            n_bad++; $display("FAIL stall_hold: line %b want %b", {sd_cmd_oe, sd_cmd_o}, snap);
        end
        stall = 0;
        wait_done(got, rdy, nxt);
        repeat (60) @(posedge clk);
        #1;
        scan(f, ntx, nall, ok);
        n_cmp++;
        if ({got, f} !== {1'b1, frame_of(idx, arg)}) begin
            n_bad++;
            $display("FAIL stall_frame: done %0d frame %h want 1 %h", got, f, frame_of(idx, arg));
        end
        n_cmp++;
        if ({ntx, ok, cmd_ready} !== {32'd48, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL stall_ignore: oe_ticks %0d idle_ok %0d ready %0d want 48 1 1",
                     ntx, ok, cmd_ready);
        end
    endtask

    task automatic test_random();
        bit got, ok, tmo, bc, be; logic rdy, nxt; logic [47:0] f, r; int ntx, nall, d, exp_n;
        logic [5:0] idx, ridx; logic [31:0] arg, rd; logic ren, chk; logic [2:0] exp_e;
        for (int k = 0; k < 10; k++) begin
            tdiv = $urandom_range(2, 6);
            idx = 6'($urandom); arg = $urandom; ridx = 6'($urandom); rd = $urandom;
            ren = 1'($urandom); chk = 1'($urandom); d = $urandom_range(0, 12);
            tmo = ren && ($urandom_range(0, 4) == 0);
            bc = 1'($urandom); be = ($urandom_range(0, 3) == 0);
            r = resp_of(ridx, rd, bc, be);
            issue(idx, arg, ren, chk, d, r, ren && !tmo);
            wait_done(got, rdy, nxt);
            scan(f, ntx, nall, ok);
            exp_n = !ren ? 56 : (tmo ? 120 : 48 + d + 1 + 47 + 8);
            exp_e = {tmo, ren && !tmo && chk && bc, ren && !tmo && be};
            if (ren && !tmo) begin m_ridx = ridx; m_rdata = rd; end
            n_cmp++;
            if ({got, f} !== {1'b1, frame_of(idx, arg)}) begin
                n_bad++;
                $display("FAIL rand%0d_frame: done %0d frame %h want 1 %h",
                         k, got, f, frame_of(idx, arg));
            end
            n_cmp++;
            if ({nall, ntx, ok} !== {exp_n, 32'd48, 1'b1}) begin
                n_bad++;
                $display("FAIL rand%0d_ticks: ticks %0d oe_ticks %0d idle_ok %0d want %0d 48 1",
                         k, nall, ntx, ok, exp_n);
            end
            n_cmp++;
            if ({err_timeout, err_crc, err_end} !== exp_e) begin
                n_bad++;
                $display("FAIL rand%0d_err: got %b want %b", k, {err_timeout, err_crc, err_end}, exp_e);
            end
            n_cmp++;
            if ({resp_index, resp_data} !== {m_ridx, m_rdata}) begin
                n_bad++;
                $display("FAIL rand%0d_resp: got %h %h want %h %h",
                         k, resp_index, resp_data, m_ridx, m_rdata);
            end
        end
    endtask

    initial begin
        test_reset();
        test_cmd0();
        test_cmd8();
        test_cmd17_crc();
        test_timeout();
        test_rst_mid();
        test_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
